// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential fetch requests, buffers in-order
// responses in a small prefetch queue, and flushes on control-flow redirect.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned PC_STEP  = 2,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [15:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [15:0] imem_rsp_data_i,
    output logic        fetch_valid_o,
    input  logic        fetch_ready_i,
    output logic [15:0] fetch_pc_o,
    output logic [15:0] fetch_instr_o,
    input  logic        redirect_i,
    input  logic [15:0] redirect_pc_i
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [15:0]      pc_q, pc_d;
    logic [15:0]      rsp_pc_q, rsp_pc_d;
    logic [15:0]      qpc_q [DEPTH];
    logic [15:0]      qpc_d [DEPTH];
    logic [15:0]      qinstr_q [DEPTH];
    logic [15:0]      qinstr_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             req_fire, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign fetch_valid_o   = (count_q != '0);
    assign fetch_pc_o      = fetch_valid_o ? qpc_q[rd_ptr_q] : 16'h0000;
    assign fetch_instr_o   = fetch_valid_o ? qinstr_q[rd_ptr_q] : 16'h0000;
    assign imem_req_addr_o = pc_q;

    // Credit rule: queued plus in-flight never exceeds DEPTH, so a push always has room.
    always_comb begin
        imem_req_valid_o = rst_n && !redirect_i
                           && ((SUM_W'(count_q) + SUM_W'(inflight_q)) < SUM_W'(DEPTH));
        req_fire   = imem_req_valid_o && imem_req_ready_i;
        push       = imem_rsp_valid_i && (drop_cnt_q == '0) && !redirect_i;
        pop        = fetch_valid_o && fetch_ready_i && !redirect_i;

        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        qpc_d      = qpc_q;
        qinstr_d   = qinstr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        drop_cnt_d = drop_cnt_q;

        if (req_fire) begin
            pc_d = pc_q + 16'(PC_STEP);
        end
        case ({req_fire, imem_rsp_valid_i})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase

        if (redirect_i) begin
            // Everything still outstanding after this edge belongs to the old stream.
            pc_d       = {redirect_pc_i[15:1], 1'b0};
            rsp_pc_d   = {redirect_pc_i[15:1], 1'b0};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            drop_cnt_d = inflight_d;
        end else begin
            if (imem_rsp_valid_i && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
            if (push) begin
                qpc_d[wr_ptr_q]    = rsp_pc_q;
                qinstr_d[wr_ptr_q] = imem_rsp_data_i;
                wr_ptr_d           = ptr_inc(wr_ptr_q);
                rsp_pc_d           = rsp_pc_q + 16'(PC_STEP);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Payload storage needs no reset; the head outputs are masked while empty.
    always_ff @(posedge clk) begin
        qpc_q    <= qpc_d;
        qinstr_q <= qinstr_d;
    end

    a_no_push_full : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count_q == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with a latency-modelled instruction memory.
module tb_fetch_unit;

    localparam int unsigned DEPTH    = 2;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [15:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [15:0] imem_rsp_data_i;
    logic        fetch_valid_o;
    logic        fetch_ready_i;
    logic [15:0] fetch_pc_o;
    logic [15:0] fetch_instr_o;
    logic        redirect_i;
    logic [15:0] redirect_pc_i;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .PC_STEP(2), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .fetch_valid_o    (fetch_valid_o),
        .fetch_ready_i    (fetch_ready_i),
        .fetch_pc_o       (fetch_pc_o),
        .fetch_instr_o    (fetch_instr_o),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i)
    );

    typedef struct { logic [15:0] pc; logic [15:0] instr; } exp_t;
    typedef struct { logic [15:0] addr; int due; int epoch; } mreq_t;

    exp_t        exp_q[$];
    mreq_t       mem_q[$];
    int          cyc       = 0;
    int          epoch     = 0;
    int          rsp_epoch = 0;
    int          avail     = 0;
    int          lat_min   = 1;
    int          lat_max   = 1;
    logic [15:0] model_addr = RESET_PC;
    int          n_checks  = 0;
    int          n_fail    = 0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compare at the falling edge, then advance the model to the next rising edge.
    int    occ;
    mreq_t mr;
    exp_t  e;
    always @(negedge clk) begin
        if (!rst_n) begin
            check("req_valid_in_reset", 16'(imem_req_valid_o), 16'h0);
            exp_q.delete();
            avail      = 0;
            epoch++;
            model_addr = RESET_PC;
        end else begin
            occ = exp_q.size();
            foreach (mem_q[i]) if (mem_q[i].epoch != epoch) occ++;
            if (imem_rsp_valid_i && rsp_epoch != epoch) occ++;
            check("req_valid", 16'(imem_req_valid_o),
                  16'(!redirect_i && (occ < int'(DEPTH))));
            if (imem_req_valid_o) check("req_addr", imem_req_addr_o, model_addr);
            check("fetch_valid", 16'(fetch_valid_o), 16'(avail > 0));
            if (fetch_valid_o && exp_q.size() > 0) begin
                check("fetch_pc", fetch_pc_o, exp_q[0].pc);
                check("fetch_instr", fetch_instr_o, exp_q[0].instr);
            end else if (!fetch_valid_o) begin
                check("empty_pc", fetch_pc_o, 16'h0000);
                check("empty_instr", fetch_instr_o, 16'h0000);
            end

            if (imem_req_valid_o && imem_req_ready_i) begin
                mr.addr  = imem_req_addr_o;
                mr.due   = cyc + $urandom_range(lat_max, lat_min);
                mr.epoch = epoch;
                mem_q.push_back(mr);
                e.pc     = model_addr;
                e.instr  = mem_word(model_addr);
                if (!redirect_i) exp_q.push_back(e);
                model_addr = model_addr + 16'd2;
            end
            if (redirect_i) begin
                exp_q.delete();
                avail      = 0;
                epoch++;
                model_addr = {redirect_pc_i[15:1], 1'b0};
            end else begin
                if (imem_rsp_valid_i && rsp_epoch == epoch) avail++;
                if (fetch_valid_o && fetch_ready_i && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    avail--;
                end
            end
        end
    end

    // One clock of stimulus; the memory model presents due responses in order.
    task automatic step(input bit rst, input bit red, input logic [15:0] tgt,
                        input bit frdy, input bit mrdy);
        @(posedge clk);
        #1;
        cyc++;
        rst_n            = !rst;
        redirect_i       = red;
        redirect_pc_i    = tgt;
        fetch_ready_i    = frdy;
        imem_req_ready_i = mrdy;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 16'($urandom);
        if (rst) begin
            mem_q.delete();
        end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = mem_word(mem_q[0].addr);
            rsp_epoch        = mem_q[0].epoch;
            void'(mem_q.pop_front());
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        redirect_i       = 1'b0;
        redirect_pc_i    = 16'h0000;
        fetch_ready_i    = 1'b1;
        imem_req_ready_i = 1'b1;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 16'h0000;

        step(1, 0, 16'h0, 1, 1);
        repeat (10) step(0, 0, 16'h0, 1, 1);

        step(1, 0, 16'h0, 1, 1);
        repeat (6) step(0, 0, 16'h0, 0, 1);
        repeat (8) step(0, 0, 16'h0, 1, 1);

        lat_min = 3; lat_max = 3;
        repeat (4) step(0, 0, 16'h0, 1, 1);
        step(0, 1, 16'h0040, 1, 1);
        repeat (12) step(0, 0, 16'h0, 1, 1);

        lat_min = 1; lat_max = 1;
        repeat (3) step(0, 0, 16'h0, 1, 1);
        step(0, 1, 16'h0013, 1, 1);
        repeat (4) step(0, 0, 16'h0, 1, 1);
        step(0, 1, 16'h0100, 1, 1);
        repeat (5) step(0, 0, 16'h0, 1, 1);

        step(0, 1, 16'hFFFA, 1, 1);
        repeat (8) step(0, 0, 16'h0, 1, 1);

        lat_min = 2; lat_max = 2;
        repeat (5) step(0, 0, 16'h0, 0, 1);
        step(1, 0, 16'h0, 0, 1);
        repeat (6) step(0, 0, 16'h0, 1, 1);

        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(199, 0) == 0),
                 ($urandom_range(11, 0) == 0),
                 16'($urandom),
                 ($urandom_range(99, 0) < 70),
                 ($urandom_range(99, 0) < 70));
        end
        repeat (10) step(0, 0, 16'h0, 1, 1);

        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
